// File: rtl/shift_sequencer.sv
// shift_sequencer
// Sequences an external 4-bit single-step shifter to perform multi-step
// logical, arithmetic and rotate shifts. Each SHIFT cycle feeds the working
// value to the shifter and captures its output. The final value and the last
// bit shifted out are then presented for one DONE cycle.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   start        request pulse, sampled only in IDLE
//   dir          0 = left, 1 = right
//   mode         00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//   amount       number of single-bit steps (AMT_W bits)
//   data_in      4-bit operand
//   busy         high in SHIFT and DONE
//   done         one-cycle completion pulse
//   result       final value, held until the next accepted start or reset
//   carry_out    last bit shifted out, held with result
//   sh_d         operand to the shifter
//   sh_select    shifter direction
//   sh_in_right  fill into bit 0 (left shifts)
//   sh_in_left   fill into bit 3 (right shifts)
//   sh_s         shifter result
//   sh_bb_right  bit leaving bit 0 on a right shift
//   sh_bb_left   bit leaving bit 3 on a left shift
module shift_sequencer #(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [3:0]       data_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result,
  output logic             carry_out,
  output logic [3:0]       sh_d,
  output logic             sh_select,
  output logic             sh_in_right,
  output logic             sh_in_left,
  input  logic [3:0]       sh_s,
  input  logic             sh_bb_right,
  input  logic             sh_bb_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       work_q;
  logic             carry_q;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic [AMT_W-1:0] count_q;
  logic [3:0]       result_q;
  logic             carry_out_q;

  logic [3:0]       work_d;
  logic             carry_d;
  logic             fill;

  // Drive the shifter only while shifting. The shifter ORs its fill inputs
  // into the data, so the fill on the unused side must be held at 0.
  // The rotate fill comes from the shifter's bit-bucket outputs. Those depend
  // only on sh_d and sh_select, so no combinational loop is formed.
  always_comb begin
    sh_d        = 4'b0000;
    sh_select   = 1'b0;
    sh_in_right = 1'b0;
    sh_in_left  = 1'b0;
    fill        = 1'b0;
    if (state_q == SHIFT) begin
      sh_d      = work_q;
      sh_select = dir_q;
      case (mode_q)
        2'b01:   fill = dir_q ? work_q[3] : 1'b0;
        2'b10:   fill = dir_q ? sh_bb_right : sh_bb_left;
        default: fill = 1'b0;
      endcase
      if (dir_q) sh_in_left  = fill;
      else       sh_in_right = fill;
    end
  end

  // Value captured at the end of a shift step.
  // The carry is the bit that fell out on the active side.
  assign work_d  = sh_s;
  assign carry_d = dir_q ? sh_bb_right : sh_bb_left;

  // Sequencer FSM.
  // result and carry_out are loaded on the edge that enters DONE, so they are
  // already valid in the cycle where done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= 4'b0000;
      carry_q     <= 1'b0;
      dir_q       <= 1'b0;
      mode_q      <= 2'b00;
      count_q     <= '0;
      result_q    <= 4'b0000;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q  <= data_in;
            dir_q   <= dir;
            mode_q  <= mode;
            count_q <= amount;
            carry_q <= 1'b0;
            if (amount != '0) begin
              state_q <= SHIFT;
            end else begin
              state_q     <= DONE;
              result_q    <= data_in;
              carry_out_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          work_q  <= work_d;
          carry_q <= carry_d;
          count_q <= count_q - AMT_W'(1);
          if (count_q == AMT_W'(1)) begin
            state_q     <= DONE;
            result_q    <= work_d;
            carry_out_q <= carry_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer. It models the external 4-bit shifter and
// keeps a scoreboard of expected {result, carry, latency} entries. Each entry
// is pushed when a start is driven and popped when the DUT raises done.
module tb_shift_sequencer;

  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             dir;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [3:0]       data_in;
  logic             busy;
  logic             done;
  logic [3:0]       result;
  logic             carry_out;
  logic [3:0]       sh_d;
  logic             sh_select;
  logic             sh_in_right;
  logic             sh_in_left;
  logic [3:0]       sh_s;
  logic             sh_bb_right;
  logic             sh_bb_left;

  typedef struct {
    logic [3:0] res;
    logic       c;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  // External shifter: the fill bit is ORed with the shifted data.
  assign sh_s = sh_select ? ({1'b0, sh_d[3:1]} | {sh_in_left, 3'b000})
                          : ({sh_d[2:0], 1'b0} | {3'b000, sh_in_right});
  assign sh_bb_right = sh_d[0];
  assign sh_bb_left  = sh_d[3];

  shift_sequencer #(.AMT_W(AMT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dir         (dir),
    .mode        (mode),
    .amount      (amount),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .carry_out   (carry_out),
    .sh_d        (sh_d),
    .sh_select   (sh_select),
    .sh_in_right (sh_in_right),
    .sh_in_left  (sh_in_left),
    .sh_s        (sh_s),
    .sh_bb_right (sh_bb_right),
    .sh_bb_left  (sh_bb_left)
  );

  // Reference model. It returns {carry, value} after the given number of steps.
  function automatic logic [4:0] ref_shift(input logic [3:0] d, input logic dr,
                                           input logic [1:0] md, input int steps);
    logic [3:0] w;
    logic       c;
    logic       f;
    w = d;
    c = 1'b0;
    for (int i = 0; i < steps; i++) begin
      if (dr) begin
        f = (md == 2'b01) ? w[3] : (md == 2'b10) ? w[0] : 1'b0;
        c = w[0];
        w = {f, w[3:1]};
      end else begin
        f = (md == 2'b10) ? w[3] : 1'b0;
        c = w[3];
        w = {w[2:0], f};
      end
    end
    return {c, w};
  endfunction

  // Runs one operation starting from IDLE at a negedge. It checks per-cycle
  // busy/done and the shifter drive, and pops the scoreboard when done
  // appears. It returns at the negedge of cycle lat+1, which is back in IDLE.
  task automatic do_op(input logic [3:0] d, input logic dr, input logic [1:0] md,
                       input logic [AMT_W-1:0] amt, input bit extra_starts,
                       input string tag);
    exp_t       e;
    exp_t       got;
    logic [4:0] r;
    logic [4:0] t;
    int         lat;
    r     = ref_shift(d, dr, md, int'(amt));
    lat   = (amt == '0) ? 1 : int'(amt) + 1;
    e.res = r[3:0];
    e.c   = r[4];
    e.lat = lat;
    sb.push_back(e);
    start = 1'b1; data_in = d; dir = dr; mode = md; amount = amt;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    data_in = 4'($urandom);
    dir     = 1'($urandom);
    mode    = 2'($urandom);
    amount  = AMT_W'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      checks++;
      if (busy !== (k <= lat)) begin
        fails++;
        $display("[TB] FAIL %s busy cycle %0d: got %b want %b", tag, k, busy, (k <= lat));
      end
      if (k <= int'(amt)) begin
        t = ref_shift(d, dr, md, k - 1);
        checks++;
        if (sh_d !== t[3:0] || sh_select !== dr) begin
          fails++;
          $display("[TB] FAIL %s shifter drive cycle %0d: got d=%b sel=%b want d=%b sel=%b",
                   tag, k, sh_d, sh_select, t[3:0], dr);
        end
        checks++;
        if ((dr ? sh_in_right : sh_in_left) !== 1'b0) begin
          fails++;
          $display("[TB] FAIL %s unused fill cycle %0d: got %b want 0", tag, k,
                   dr ? sh_in_right : sh_in_left);
        end
      end else begin
        checks++;
        if ({sh_d, sh_select, sh_in_right, sh_in_left} !== 7'b0) begin
          fails++;
          $display("[TB] FAIL %s shifter idle cycle %0d: got %b want 0000000", tag, k,
                   {sh_d, sh_select, sh_in_right, sh_in_left});
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL %s unexpected done cycle %0d: got done=1 want done=0", tag, k);
        end else begin
          got = sb.pop_front();
          if (result !== got.res || carry_out !== got.c || k != got.lat) begin
            fails++;
            $display("[TB] FAIL %s completion: got res=%b c=%b cycle=%0d want res=%b c=%b cycle=%0d",
                     tag, result, carry_out, k, got.res, got.c, got.lat);
          end
        end
      end
      if (extra_starts) begin
        start   = (k >= 2 && k <= 5);
        data_in = 4'($urandom);
        dir     = 1'($urandom);
        mode    = 2'($urandom);
        amount  = AMT_W'($urandom);
      end
      if (k == lat + 1) start = 1'b0;
      else @(negedge clk);
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s timeout: got no done want done at cycle %0d", tag, lat);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dir = 1'b0; mode = 2'b00; amount = '0; data_in = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, result, carry_out} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset outputs: got %b want 0000000", {busy, done, result, carry_out});
    end
    checks++;
    if ({sh_d, sh_select, sh_in_right, sh_in_left} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset shifter: got %b want 0000000", {sh_d, sh_select, sh_in_right, sh_in_left});
    end
    // Reset and start in the same cycle: reset must win.
    start = 1'b1; data_in = 4'b1010; amount = 3'd2;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_vs_start: got busy=%b done=%b want 0 0", busy, done);
    end
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_vectors();
    do_op(4'b1011, 1'b1, 2'b00, 3'd1, 1'b0, "logical_right_1");
    do_op(4'b1000, 1'b1, 2'b01, 3'd2, 1'b0, "arith_right_2");
    do_op(4'b1001, 1'b0, 2'b10, 3'd3, 1'b0, "rotate_left_3");
    do_op(4'b0110, 1'b0, 2'b00, 3'd0, 1'b0, "amount_zero");
    do_op(4'b1011, 1'b1, 2'b10, 3'd6, 1'b0, "rotate_right_wrap");
    do_op(4'b1010, 1'b0, 2'b11, 3'd2, 1'b0, "reserved_mode");
  endtask

  task automatic test_ignore_start();
    do_op(4'b1111, 1'b0, 2'b00, 3'd7, 1'b1, "ignore_start");
  endtask

  task automatic test_reset_mid();
    do_op(4'b1011, 1'b1, 2'b00, 3'd1, 1'b0, "pre_reset");
    start = 1'b1; data_in = 4'b1010; dir = 1'b0; mode = 2'b00; amount = 3'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_mid busy before reset: got %b want 1", busy);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, result, carry_out, sh_d} !== 11'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid state: got %b want 00000000000", {busy, done, result, carry_out, sh_d});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_mid stray activity: got busy=%b done=%b want 0 0", busy, done);
      end
    end
    do_op(4'b0011, 1'b0, 2'b01, 3'd3, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      do_op(4'($urandom), 1'($urandom), 2'($urandom), AMT_W'($urandom), 1'b0, "random_b2b");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
